stream_selector: RTL and testbench

//   N-channel, W-bit stream selector with valid/ready handshakes and a registered output.

---
 rtl/stream_selector.sv | 94 +++++++++
 tb/tb_stream_selector.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_selector.sv
// Parametrised N:1 stream selector with valid/ready handshakes and a one-entry
// registered output stage; fixed-select or round-robin channel arbitration.
module stream_selector #(
  parameter int NUM_CH = 4,
  parameter int W      = 8,
  parameter int CNT_W  = 16,
  localparam int SEL_W = $clog2(NUM_CH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  input  logic [NUM_CH-1:0]     in_valid,
  input  logic [NUM_CH*W-1:0]   in_data,
  output logic [NUM_CH-1:0]     in_ready,
  output logic                  out_valid,
  output logic [W-1:0]          out_data,
  output logic [SEL_W-1:0]      out_ch,
  input  logic                  out_ready,
  output logic [CNT_W-1:0]      xfer_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);

  logic [W-1:0]     ch_data [NUM_CH];
  logic [SEL_W-1:0] rr_ptr;
  logic             load_en;
  logic             gnt_vld;
  logic [SEL_W-1:0] gnt_idx;
  logic [SEL_W-1:0] cand;
  logic             accept;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
    assign ch_data[i] = in_data[i*W +: W];
  end

  assign load_en = !out_valid || out_ready;

  // Round-robin search starts just after the last served channel.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    if (!mode) begin
      if (int'(sel) < NUM_CH) begin
        if (in_valid[sel]) begin
          gnt_vld = 1'b1;
          gnt_idx = sel;
        end
      end
    end else begin
      for (int k = 1; k <= NUM_CH; k++) begin
        cand = SEL_W'((int'(rr_ptr) + k) % NUM_CH);
        if (!gnt_vld && in_valid[cand]) begin
          gnt_vld = 1'b1;
          gnt_idx = cand;
        end
      end
    end
  end

  assign accept = !rst && load_en && gnt_vld;

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      in_ready[i] = accept && (gnt_idx == SEL_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      xfer_cnt  <= '0;
      rr_ptr    <= LAST_CH;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= ch_data[gnt_idx];
        out_ch    <= gnt_idx;
        rr_ptr    <= gnt_idx;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (out_valid && out_ready && (xfer_cnt != CNT_MAX)) begin
        xfer_cnt <= xfer_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_stream_selector.sv
// Bench for stream_selector: a 4-channel instance checked against a cycle model
// with an output scoreboard, plus a 3-channel/4-bit-counter instance for bounds.
module tb_stream_selector;

  logic        clk;
  logic        rst;
  logic        mode;
  logic [1:0]  sel;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_ch;
  logic        out_ready;
  logic [15:0] xfer_cnt;

  logic        b_rst;
  logic        b_mode;
  logic [1:0]  b_sel;
  logic [2:0]  b_in_valid;
  logic [23:0] b_in_data;
  logic [2:0]  b_in_ready;
  logic        b_out_valid;
  logic [7:0]  b_out_data;
  logic [1:0]  b_out_ch;
  logic        b_out_ready;
  logic [3:0]  b_xfer_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  logic        m_ov  = 1'b0;
  logic [15:0] m_cnt = '0;
  logic [1:0]  m_rr  = 2'd3;
  logic [9:0]  sb [$];

  stream_selector #(.NUM_CH(4), .W(8), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch),
    .out_ready(out_ready), .xfer_cnt(xfer_cnt)
  );

  stream_selector #(.NUM_CH(3), .W(8), .CNT_W(4)) u_dut3 (
    .clk(clk), .rst(b_rst), .mode(b_mode), .sel(b_sel),
    .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
    .out_valid(b_out_valid), .out_data(b_out_data), .out_ch(b_out_ch),
    .out_ready(b_out_ready), .xfer_cnt(b_xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock of the 4-channel instance: check against the model, then advance it.
  task automatic cyc();
    logic       load;
    logic       g;
    logic [1:0] gi;
    logic [1:0] c;
    logic [3:0] exp_rdy;
    #1;
    load = !m_ov || out_ready;
    g = 1'b0;
    gi = 2'd0;
    if (!mode) begin
      if (in_valid[sel]) begin
        g = 1'b1;
        gi = sel;
      end
    end else begin
      for (int k = 1; k <= 4; k++) begin
        c = m_rr + 2'(k);
        if (!g && in_valid[c]) begin
          g = 1'b1;
          gi = c;
        end
      end
    end
    exp_rdy = (!rst && load && g) ? (4'b0001 << gi) : 4'b0000;

    n_checks++;
    if (in_ready !== exp_rdy) $display("FAIL in_ready: got %b expected %b at %0t", in_ready, exp_rdy, $time);
    else n_pass++;
    n_checks++;
    if (out_valid !== m_ov) $display("FAIL out_valid: got %b expected %b at %0t", out_valid, m_ov, $time);
    else n_pass++;
    n_checks++;
    if (xfer_cnt !== m_cnt) $display("FAIL xfer_cnt: got %0d expected %0d at %0t", xfer_cnt, m_cnt, $time);
    else n_pass++;
    if (m_ov) begin
      n_checks++;
      if (sb.size() == 0) $display("FAIL scoreboard: output valid with no expected entry at %0t", $time);
      else if ({out_ch, out_data} !== sb[0])
        $display("FAIL out_word: got ch%0d %h expected ch%0d %h at %0t",
                 out_ch, out_data, sb[0][9:8], sb[0][7:0], $time);
      else n_pass++;
    end

    if (rst) begin
      m_ov = 1'b0;
      m_cnt = '0;
      m_rr = 2'd3;
      sb.delete();
    end else begin
      if (m_ov && out_ready) begin
        if (sb.size() != 0) void'(sb.pop_front());
        if (m_cnt != 16'hFFFF) m_cnt++;
      end
      if (exp_rdy != 4'b0000) begin
        m_ov = 1'b1;
        m_rr = gi;
        sb.push_back({gi, in_data[gi*8 +: 8]});
      end else if (out_ready) begin
        m_ov = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 4'b0000;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 4'b1111;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc();
      n_checks++;
      if (in_ready !== 4'b0000) $display("FAIL reset_in_ready: got %b expected 0000", in_ready);
      else n_pass++;
      n_checks++;
      if (out_valid !== 1'b0 || xfer_cnt !== 16'd0)
        $display("FAIL reset_state: got valid=%b cnt=%0d expected valid=0 cnt=0", out_valid, xfer_cnt);
      else n_pass++;
    end
    rst = 1'b0;
  endtask

  task automatic test_fixed();
    do_reset();
    mode = 1'b0;
    sel = 2'd2;
    in_valid = 4'b1111;
    in_data = {8'h33, 8'hA5, 8'h22, 8'h11};
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 4'b0100) $display("FAIL fixed_in_ready: got %b expected 0100", in_ready);
    else n_pass++;
    cyc();
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_ch !== 2'd2)
      $display("FAIL fixed_first: got v=%b d=%h ch=%0d expected v=1 d=a5 ch=2", out_valid, out_data, out_ch);
    else n_pass++;
    cyc();
    cyc();
    cyc();
    n_checks++;
    if (xfer_cnt !== 16'd3) $display("FAIL fixed_count: got %0d expected 3", xfer_cnt);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [1:0] seq [6];
    seq = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3};
    do_reset();
    mode = 1'b1;
    in_valid = 4'b1011;
    in_data = {8'h44, 8'h33, 8'h22, 8'h11};
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cyc();
      n_checks++;
      if (out_ch !== seq[k] || out_valid !== 1'b1)
        $display("FAIL rr_seq[%0d]: got ch=%0d v=%b expected ch=%0d v=1", k, out_ch, out_valid, seq[k]);
      else n_pass++;
    end
  endtask

  task automatic test_back_pressure();
    do_reset();
    mode = 1'b0;
    sel = 2'd1;
    in_valid = 4'b0010;
    in_data = {8'h00, 8'h00, 8'h3C, 8'h00};
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    in_data = {8'h00, 8'h00, 8'hC3, 8'h00};
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (in_ready !== 4'b0000) $display("FAIL bp_in_ready[%0d]: got %b expected 0000", i, in_ready);
      else n_pass++;
      cyc();
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h3C || out_ch !== 2'd1)
        $display("FAIL bp_hold[%0d]: got v=%b d=%h ch=%0d expected v=1 d=3c ch=1", i, out_valid, out_data, out_ch);
      else n_pass++;
    end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 4'b0010) $display("FAIL bp_release_ready: got %b expected 0010", in_ready);
    else n_pass++;
    cyc();
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hC3 || xfer_cnt !== 16'd1)
      $display("FAIL bp_no_bubble: got v=%b d=%h cnt=%0d expected v=1 d=c3 cnt=1", out_valid, out_data, xfer_cnt);
    else n_pass++;
  endtask

  task automatic test_mode_switch();
    do_reset();
    mode = 1'b0;
    sel = 2'd1;
    in_valid = 4'b1111;
    in_data = {8'h44, 8'h33, 8'h22, 8'h11};
    out_ready = 1'b1;
    cyc();
    mode = 1'b1;
    cyc();
    n_checks++;
    if (out_ch !== 2'd2 || out_data !== 8'h33)
      $display("FAIL switch_resume: got ch=%0d d=%h expected ch=2 d=33", out_ch, out_data);
    else n_pass++;
    cyc();
    n_checks++;
    if (out_ch !== 2'd3) $display("FAIL switch_next: got ch=%0d expected 3", out_ch);
    else n_pass++;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 99) < 2);
      mode = 1'($urandom_range(0, 1));
      sel = 2'($urandom_range(0, 3));
      in_valid = 4'($urandom_range(0, 15));
      in_data = $urandom;
      out_ready = ($urandom_range(0, 99) < 70);
      cyc();
    end
    rst = 1'b0;
    in_valid = 4'b0000;
    out_ready = 1'b1;
    cyc();
    cyc();
  endtask

  task automatic b_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_bounds();
    b_rst = 1'b0;
    b_mode = 1'b0;
    b_sel = 2'd3;
    b_in_valid = 3'b111;
    b_in_data = {8'h03, 8'h02, 8'h01};
    b_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (b_in_ready !== 3'b000) $display("FAIL bounds_sel3_ready[%0d]: got %b expected 000", i, b_in_ready);
      else n_pass++;
      b_step();
      n_checks++;
      if (b_out_valid !== 1'b0) $display("FAIL bounds_sel3_valid[%0d]: got %b expected 0", i, b_out_valid);
      else n_pass++;
    end
    b_sel = 2'd0;
    for (int i = 0; i < 20; i++) b_step();
    n_checks++;
    if (b_xfer_cnt !== 4'd15 || b_out_valid !== 1'b1)
      $display("FAIL bounds_saturate: got cnt=%0d v=%b expected cnt=15 v=1", b_xfer_cnt, b_out_valid);
    else n_pass++;
    b_rst = 1'b1;
    #1;
    n_checks++;
    if (b_in_ready !== 3'b000) $display("FAIL bounds_rst_ready: got %b expected 000", b_in_ready);
    else n_pass++;
    b_step();
    n_checks++;
    if (b_out_valid !== 1'b0 || b_xfer_cnt !== 4'd0)
      $display("FAIL bounds_rst_flush: got v=%b cnt=%0d expected v=0 cnt=0", b_out_valid, b_xfer_cnt);
    else n_pass++;
    b_rst = 1'b0;
    b_mode = 1'b1;
    b_step();
    n_checks++;
    if (b_out_ch !== 2'd0 || b_out_data !== 8'h01)
      $display("FAIL bounds_rr_restart: got ch=%0d d=%h expected ch=0 d=01", b_out_ch, b_out_data);
    else n_pass++;
    b_step();
    n_checks++;
    if (b_out_ch !== 2'd1) $display("FAIL bounds_rr_next: got ch=%0d expected 1", b_out_ch);
    else n_pass++;
    b_step();
    n_checks++;
    if (b_out_ch !== 2'd2) $display("FAIL bounds_rr_wrap: got ch=%0d expected 2", b_out_ch);
    else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    mode = 1'b0;
    sel = 2'd0;
    in_valid = 4'b0000;
    in_data = '0;
    out_ready = 1'b1;
    b_rst = 1'b1;
    b_mode = 1'b0;
    b_sel = 2'd0;
    b_in_valid = 3'b000;
    b_in_data = '0;
    b_out_ready = 1'b1;
    @(negedge clk);
    test_reset();
    test_fixed();
    test_round_robin();
    test_back_pressure();
    test_mode_switch();
    test_random();
    test_bounds();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
